// File: rtl/puf_cmd_ctrl_pkg.sv
// Shared definitions for the PUF command controller: frame layout, opcode
// values, FSM state encoding and status-byte bit positions.
package puf_cmd_ctrl_pkg;

    localparam int FRAME_W = 136;
    localparam int OP_W    = 8;
    localparam int DATA_W  = 128;

    localparam logic [OP_W-1:0] OP_EXC_DD  = 8'd1;
    localparam logic [OP_W-1:0] OP_EXC_XOR = 8'd2;
    localparam logic [OP_W-1:0] OP_RD_DD   = 8'd3;
    localparam logic [OP_W-1:0] OP_RD_XOR  = 8'd4;
    localparam logic [OP_W-1:0] OP_WR_DDC  = 8'd5;
    localparam logic [OP_W-1:0] OP_WR_XORC = 8'd6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXCITE  = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_REPLY   = 3'd5;

    localparam int STAT_ILLEGAL = 7;
    localparam int STAT_OVERRUN = 6;
    localparam int STAT_SAT     = 5;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op >= OP_EXC_DD) && (op <= OP_WR_XORC);
    endfunction

endpackage

// File: rtl/puf_cmd_ctrl_excite_timer.sv
// Excitation-length counter.
//   i_load : load i_n (one cycle, before the window opens)
//   i_en   : window active, count down
//   o_done : last cycle of the window
module puf_cmd_ctrl_excite_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_n,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_n;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    // <= 1 rather than == 1 so a window can never hang on a zero count.
    assign o_done = i_en && (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/puf_cmd_ctrl.sv
// Command controller between the SPI slave and the DD-/XOR-PUF macros.
// Decodes each 136-bit frame {opcode, payload}, runs timed excitation
// windows, captures PUF responses, holds challenges and builds the reply.
//   i_clk, i_reset         : clock, async active-high reset
//   i_received, i_rx_valid : incoming frame and its one-cycle strobe
//   i_dd_resp, i_xor_resp  : PUF responses
//   o_excite_dd/xor        : registered excitation windows
//   o_dd_chal, o_xor_chal  : challenge registers
//   o_to_send, o_tx_load   : reply word {status, data} and its load strobe
//   o_busy                 : FSM not idle
module puf_cmd_ctrl
    import puf_cmd_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [FRAME_W-1:0] i_received,
    input  logic               i_rx_valid,
    input  logic [DATA_W-1:0]  i_dd_resp,
    input  logic [DATA_W-1:0]  i_xor_resp,
    output logic               o_excite_dd,
    output logic               o_excite_xor,
    output logic [DATA_W-1:0]  o_dd_chal,
    output logic [DATA_W-1:0]  o_xor_chal,
    output logic [FRAME_W-1:0] o_to_send,
    output logic               o_tx_load,
    output logic               o_busy
);

    logic [2:0]         r_state, w_next;
    logic [FRAME_W-1:0] r_cmd;
    logic [DATA_W-1:0]  r_dd_reg, r_xor_reg;
    logic               r_overrun;
    logic               r_exc_dd, r_exc_xor;
    logic               r_tx_load;
    logic [FRAME_W-1:0] r_to_send;

    logic [OP_W-1:0]    w_op;
    logic [DATA_W-1:0]  w_pay;
    logic               w_is_exc, w_is_rd, w_illegal, w_sat, w_drop, w_done;
    logic [CNT_W-1:0]   w_n;
    logic [7:0]         w_status;
    logic [DATA_W-1:0]  w_data;

    assign w_op      = r_cmd[FRAME_W-1:DATA_W];
    assign w_pay     = r_cmd[DATA_W-1:0];
    assign w_is_exc  = (w_op == OP_EXC_DD) || (w_op == OP_EXC_XOR);
    assign w_is_rd   = (w_op == OP_RD_DD) || (w_op == OP_RD_XOR);
    assign w_illegal = !op_legal(w_op);
    assign w_sat     = |w_pay[DATA_W-1:CNT_W];
    assign w_n       = w_sat ? '1 : w_pay[CNT_W-1:0];
    assign w_drop    = i_rx_valid && (r_state != ST_IDLE);

    puf_cmd_ctrl_excite_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_reset),
        .i_load (r_state == ST_DECODE),
        .i_n    (w_n),
        .i_en   (r_state == ST_EXCITE),
        .o_done (w_done)
    );

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:    w_next = i_rx_valid ? ST_DECODE : ST_IDLE;
            ST_DECODE:  w_next = (w_is_exc && (w_n != '0)) ? ST_EXCITE : ST_REPLY;
            ST_EXCITE:  w_next = w_done ? ST_SETTLE : ST_EXCITE;
            ST_SETTLE:  w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_REPLY;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Status is built on the transition into REPLY; a frame dropped in that
    // same cycle is already folded into the overrun bit being reported.
    always_comb begin
        w_status               = 8'h00;
        w_status[STAT_ILLEGAL] = w_illegal;
        w_status[STAT_OVERRUN] = r_overrun | w_drop;
        w_status[STAT_SAT]     = w_is_exc && w_sat;
        w_status[2:0]          = w_op[2:0];
        if (w_op == OP_RD_DD)
            w_data = r_dd_reg;
        else if (w_op == OP_RD_XOR)
            w_data = r_xor_reg;
        else if (w_illegal)
            w_data = w_pay;
        else
            w_data = '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_dd_reg   <= '0;
            r_xor_reg  <= '0;
            o_dd_chal  <= '0;
            o_xor_chal <= '0;
            r_overrun  <= 1'b0;
            r_exc_dd   <= 1'b0;
            r_exc_xor  <= 1'b0;
            r_tx_load  <= 1'b0;
            r_to_send  <= '0;
        end else begin
            r_state   <= w_next;
            if ((r_state == ST_IDLE) && i_rx_valid)
                r_cmd <= i_received;
            r_exc_dd  <= (w_next == ST_EXCITE) && (w_op == OP_EXC_DD);
            r_exc_xor <= (w_next == ST_EXCITE) && (w_op == OP_EXC_XOR);
            if (r_state == ST_CAPTURE) begin
                if (w_op == OP_EXC_DD)
                    r_dd_reg  <= i_dd_resp;
                else
                    r_xor_reg <= i_xor_resp;
            end
            if (r_state == ST_DECODE) begin
                if (w_op == OP_WR_DDC)
                    o_dd_chal  <= w_pay;
                if (w_op == OP_WR_XORC)
                    o_xor_chal <= w_pay;
            end
            // A fresh drop wins over the clear after a read reply.
            if (w_drop)
                r_overrun <= 1'b1;
            else if ((r_state == ST_REPLY) && w_is_rd)
                r_overrun <= 1'b0;
            r_tx_load <= (w_next == ST_REPLY);
            if (w_next == ST_REPLY)
                r_to_send <= {w_status, w_data};
        end
    end

    assign o_excite_dd  = r_exc_dd;
    assign o_excite_xor = r_exc_xor;
    assign o_tx_load    = r_tx_load;
    assign o_to_send    = r_to_send;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_puf_cmd_ctrl.sv
module tb_puf_cmd_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [135:0] received;
    logic         rx_valid;
    logic [127:0] dd_resp, xor_resp;
    logic         exc_dd, exc_xor, tx_load, busy;
    logic [127:0] dd_chal, xor_chal;
    logic [135:0] to_send;

    int n_chk = 0;
    int n_fail = 0;

    // Results of the last cmd() call.
    int           r_first, r_dd, r_xor, r_tx, r_both;
    logic [135:0] r_reply;
    logic [127:0] dd_v, xor_v, p, q, x;

    always #10 clk = ~clk;

    puf_cmd_ctrl #(.CNT_W(16)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_received   (received),
        .i_rx_valid   (rx_valid),
        .i_dd_resp    (dd_resp),
        .i_xor_resp   (xor_resp),
        .o_excite_dd  (exc_dd),
        .o_excite_xor (exc_xor),
        .o_dd_chal    (dd_chal),
        .o_xor_chal   (xor_chal),
        .o_to_send    (to_send),
        .o_tx_load    (tx_load),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Sends frame f, then watches from cycle t+1 (k=1) until TX_LOAD or the
    // bound. The PUF responses carry the good value only during the cycle two
    // after the last excite cycle (the capture cycle); junk otherwise.
    task automatic cmd(input logic [135:0] f, input int bound, input int dup_at,
                       input logic [135:0] fdup);
        int last;
        last = 0;
        r_first = 0; r_dd = 0; r_xor = 0; r_tx = 0; r_both = 0; r_reply = '0;
        dd_resp = ~dd_v; xor_resp = ~xor_v;
        @(negedge clk); received = f; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            if (k > 1) @(negedge clk);
            if (dup_at != 0 && k == dup_at + 1) rx_valid = 1'b0;
            if (exc_dd || exc_xor) begin
                if (r_first == 0) r_first = k;
                last = k;
            end
            if (exc_dd) r_dd++;
            if (exc_xor) r_xor++;
            if (exc_dd && exc_xor) r_both++;
            if (tx_load) begin
                r_tx = k;
                r_reply = to_send;
                break;
            end
            if (k == dup_at) begin received = fdup; rx_valid = 1'b1; end
            dd_resp  = (last != 0 && k == last + 2) ? dd_v : ~dd_v;
            xor_resp = (last != 0 && k == last + 2) ? xor_v : ~xor_v;
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        int ntx;
        rst = 1'b1; received = '0; rx_valid = 1'b0;
        dd_v  = {$urandom, $urandom, $urandom, $urandom};
        xor_v = {$urandom, $urandom, $urandom, $urandom};
        p     = {$urandom, $urandom, $urandom, $urandom};
        q     = {$urandom, $urandom, $urandom, $urandom};
        x     = {$urandom, $urandom, $urandom, $urandom};
        dd_resp = ~dd_v; xor_resp = ~xor_v;
        #45;
        chk("rst_outs", {exc_dd, exc_xor, tx_load, busy}, 4'b0);
        chk("rst_to_send", to_send, 136'd0);
        chk("rst_chal", {dd_chal, xor_chal}, 256'd0);
        @(negedge clk); rst = 1'b0;

        // DD excite, N=10
        cmd({8'd1, 128'd10}, 200, 0, '0);
        chk("dd10_first", r_first, 2);
        chk("dd10_len", r_dd, 10);
        chk("dd10_xor", r_xor, 0);
        chk("dd10_tx_at", r_tx, 14);
        chk("dd10_reply", r_reply, {8'h01, 128'd0});
        @(negedge clk);
        chk("tx_pulse_1cyc", tx_load, 0);
        chk("idle_after", busy, 0);
        cmd({8'd3, 128'd0}, 20, 0, '0);
        chk("rd_dd_tx_at", r_tx, 2);
        chk("rd_dd_reply", r_reply, {8'h03, dd_v});

        // XOR excite, N=128, then read back
        cmd({8'd2, 128'd128}, 400, 0, '0);
        chk("xor128_len", r_xor, 128);
        chk("xor128_dd", r_dd, 0);
        chk("xor128_first", r_first, 2);
        chk("xor128_tx_at", r_tx, 132);
        chk("xor128_reply", r_reply, {8'h02, 128'd0});
        cmd({8'd4, 128'd0}, 20, 0, '0);
        chk("rd_xor_reply", r_reply, {8'h04, xor_v});

        // challenge writes
        cmd({8'd5, p}, 20, 0, '0);
        chk("wr_ddc_reply", r_reply, {8'h05, 128'd0});
        chk("wr_ddc_tx_at", r_tx, 2);
        chk("dd_chal", dd_chal, p);
        cmd({8'd6, q}, 20, 0, '0);
        chk("wr_xorc_reply", r_reply, {8'h06, 128'd0});
        chk("xor_chal", xor_chal, q);
        chk("dd_chal_kept", dd_chal, p);

        // N=0: no pulse, straight to reply
        cmd({8'd1, 128'd0}, 20, 0, '0);
        chk("n0_len", r_dd, 0);
        chk("n0_tx_at", r_tx, 2);
        chk("n0_reply", r_reply, {8'h01, 128'd0});

        // illegal opcodes echo the payload
        cmd({8'd9, x}, 20, 0, '0);
        chk("ill9_reply", r_reply, {8'h81, x});
        chk("ill9_noexc", r_dd + r_xor, 0);
        cmd({8'd0, ~x}, 20, 0, '0);
        chk("ill0_reply", r_reply, {8'h80, ~x});
        cmd({8'd7, p}, 20, 0, '0);
        chk("ill7_reply", r_reply, {8'h87, p});

        // saturated N
        cmd({8'd1, 128'h1_0000}, 70000, 0, '0);
        chk("sat_len", r_dd, 65535);
        chk("sat_tx_at", r_tx, 65539);
        chk("sat_reply", r_reply, {8'h21, 128'd0});
        chk("never_both", r_both, 0);

        // overrun: second frame 3 cycles in is dropped
        dd_v = {$urandom, $urandom, $urandom, $urandom};
        cmd({8'd1, 128'd10}, 200, 3, {8'd5, q});
        chk("ovr_len", r_dd, 10);
        chk("ovr_tx_at", r_tx, 14);
        chk("ovr_reply", r_reply, {8'h41, 128'd0});
        chk("ovr_dropped", dd_chal, p);
        cmd({8'd3, 128'd0}, 20, 0, '0);
        chk("ovr_rd_reply", r_reply, {8'h43, dd_v});
        cmd({8'd3, 128'd0}, 20, 0, '0);
        chk("ovr_cleared", r_reply, {8'h03, dd_v});

        // reset in the middle of a window
        @(negedge clk); received = {8'd1, 128'd100}; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_exc", {exc_dd, busy}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_exc", exc_dd, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        ntx = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_load || exc_dd) ntx++;
        end
        chk("rst_no_tx", ntx, 0);
        chk("rst_clears", {to_send, dd_chal}, 264'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
